// File: rtl/uart_baud_pkg.sv
// Shared types and default parameters for the fractional UART baud generator.
// Contents: generator state enum and the OVERSAMPLE / DIV_W / FRAC_W /
// DEFAULT_DIV default values used by uart_baud_gen_frac and its divider.
package uart_baud_pkg;

    localparam int unsigned OVERSAMPLE_DEF  = 16;
    localparam int unsigned DIV_W_DEF       = 16;
    localparam int unsigned FRAC_W_DEF      = 4;
    localparam int unsigned DEFAULT_DIV_DEF = 27;  // 115200 baud x16 at 50 MHz

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } baud_state_e;

endpackage

// File: rtl/uart_frac_divider.sv
// Fractional clock divider producing one pulse per oversample period.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   act_int         active integer divisor (clocks per period)
//   act_frac        active fractional divisor (1/2^FRAC_W units)
//   run             generator is in RUN
//   clear           restart the period (resync or leaving RUN); wins over a due tick
//   tick_due_c      combinational: the current cycle ends a period
//   os_tick         registered one-cycle oversample pulse
module uart_frac_divider
    import uart_baud_pkg::*;
#(
    parameter int unsigned DIV_W  = DIV_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  act_int,
    input  logic [FRAC_W-1:0] act_frac,
    input  logic              run,
    input  logic              clear,
    output logic              tick_due_c,
    output logic              os_tick
);

    localparam int unsigned CNT_W = DIV_W + 1;
    localparam int unsigned SUM_W = FRAC_W + 1;

    logic [CNT_W-1:0] cnt;
    logic [FRAC_W-1:0] acc;
    logic              carry;
    logic [CNT_W-1:0] period_last;
    logic [SUM_W-1:0] acc_sum;

    // Period is act_int plus the carry left by the previous tick.
    always_comb begin
        period_last = CNT_W'(act_int) + CNT_W'(carry) - CNT_W'(1);
        acc_sum     = SUM_W'(acc) + SUM_W'(act_frac);
        tick_due_c  = run && !clear && (cnt == period_last);
    end

    // Period counter and fractional accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            os_tick <= 1'b0;
        end else if (!run || clear) begin
            cnt     <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            os_tick <= 1'b0;
        end else if (tick_due_c) begin
            cnt     <= '0;
            acc     <= acc_sum[FRAC_W-1:0];
            carry   <= acc_sum[FRAC_W];
            os_tick <= 1'b1;
        end else begin
            cnt     <= cnt + CNT_W'(1);
            os_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional UART baud generator: oversample, mid-bit and bit-boundary ticks.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   enable                   run the generator; low returns to IDLE
//   cfg_we                   write strobe for the shadow divisor
//   cfg_div_int/cfg_div_frac new integer / fractional divisor
//   resync                   restart bit phase (RX start-bit edge), RUN only
//   os_tick, mid_tick, bit_tick  registered one-cycle tick pulses
//   cfg_pending              shadow written but not yet applied
//   running                  generator in RUN
module uart_baud_gen_frac
    import uart_baud_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned FRAC_W      = FRAC_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_we,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    input  logic              resync,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              cfg_pending,
    output logic              running
);

    localparam int unsigned     OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    baud_state_e       state;
    baud_state_e       state_next;
    logic [DIV_W-1:0]  sh_int;
    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] sh_frac;
    logic [FRAC_W-1:0] act_frac;
    logic [OS_W-1:0]   os_cnt;

    logic run_c;
    logic leave_c;
    logic clear_c;
    logic tick_due_c;
    logic mid_due_c;
    logic bit_due_c;
    logic copy_c;

    uart_frac_divider #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .act_int    (act_int),
        .act_frac   (act_frac),
        .run        (run_c),
        .clear      (clear_c),
        .tick_due_c (tick_due_c),
        .os_tick    (os_tick)
    );

    // Next state, counter clear and tick decode.
    always_comb begin
        state_next = state;
        leave_c    = 1'b0;
        run_c      = (state == RUN);
        case (state)
            IDLE: begin
                if (enable && (act_int != '0)) state_next = RUN;
            end
            RUN: begin
                if (!enable || (act_int == '0)) begin
                    state_next = IDLE;
                    leave_c    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        clear_c   = leave_c || (run_c && resync);
        mid_due_c = tick_due_c && (os_cnt == OS_MID);
        bit_due_c = tick_due_c && (os_cnt == OS_LAST);
        // Divisor changes only while idle or exactly at a bit boundary.
        copy_c    = !run_c || bit_due_c;
    end

    // State, registered outputs, divisor registers and oversample counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            running     <= 1'b0;
            mid_tick    <= 1'b0;
            bit_tick    <= 1'b0;
            cfg_pending <= 1'b0;
            os_cnt      <= '0;
            sh_int      <= DIV_W'(DEFAULT_DIV);
            act_int     <= DIV_W'(DEFAULT_DIV);
            sh_frac     <= '0;
            act_frac    <= '0;
        end else begin
            state    <= state_next;
            running  <= (state_next == RUN);
            mid_tick <= mid_due_c;
            bit_tick <= bit_due_c;

            if (!run_c || clear_c) os_cnt <= '0;
            else if (tick_due_c)   os_cnt <= os_cnt + OS_W'(1);

            if (cfg_we) begin
                sh_int  <= cfg_div_int;
                sh_frac <= cfg_div_frac;
            end
            // Copy takes the pre-write shadow; a coincident write stays pending.
            if (copy_c) begin
                act_int  <= sh_int;
                act_frac <= sh_frac;
            end

            if (cfg_we)      cfg_pending <= 1'b1;
            else if (copy_c) cfg_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Scoreboard bench for uart_baud_gen_frac (OVERSAMPLE=16, DIV_W=16, FRAC_W=4).
// Stimulus pushes expected tick events (edge number + tick flags); the monitor
// pops and compares whenever any tick output is high.
module tb_uart_baud_gen_frac;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        cfg_we;
    logic [15:0] cfg_div_int;
    logic [3:0]  cfg_div_frac;
    logic        resync;
    logic        os_tick, mid_tick, bit_tick, cfg_pending, running;

    typedef struct {
        int cyc;
        int flags;   // {os, mid, bit}
    } exp_t;

    exp_t exp_q[$];
    int   obs_os[$];
    int   obs_bit[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    logic armed = 1'b0;

    uart_baud_gen_frac dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cfg_we       (cfg_we),
        .cfg_div_int  (cfg_div_int),
        .cfg_div_frac (cfg_div_frac),
        .resync       (resync),
        .os_tick      (os_tick),
        .mid_tick     (mid_tick),
        .bit_tick     (bit_tick),
        .cfg_pending  (cfg_pending),
        .running      (running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every tick observed while armed must match the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (os_tick) obs_os.push_back(cyc);
        if (bit_tick) obs_bit.push_back(cyc);
        if (armed && (os_tick || mid_tick || bit_tick)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tick_edge", cyc, -1);
            end else begin
                e = exp_q.pop_front();
                check("tick_edge", cyc, e.cyc);
                check("tick_flags", int'({os_tick, mid_tick, bit_tick}), e.flags);
            end
        end
    end

    task automatic push_ticks(input int start, input int period, input int n, input int idx0);
        exp_t e;
        int idx;
        for (int j = 1; j <= n; j++) begin
            idx     = (idx0 + j - 1) % 16;
            e.cyc   = start + period * j;
            e.flags = 4 + ((idx == 7) ? 2 : 0) + ((idx == 15) ? 1 : 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Write strobe sampled on the edge after the current negedge.
    task automatic cfg_write(input int d, input int f);
        cfg_we       = 1'b1;
        cfg_div_int  = 16'(d);
        cfg_div_frac = 4'(f);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_os"}, int'(os_tick), 0);
        check({tag, "_mid"}, int'(mid_tick), 0);
        check({tag, "_bit"}, int'(bit_tick), 0);
        check({tag, "_running"}, int'(running), 0);
        check({tag, "_pending"}, int'(cfg_pending), 0);
    endtask

    initial begin
        int n0, n1, n2, r, t, acc, c, s, last, n28;
        exp_t e;
        rst = 1'b1; enable = 1'b0; cfg_we = 1'b0; resync = 1'b0;
        cfg_div_int = '0; cfg_div_frac = '0;

        // Reset and idle hold
        #3 rst = 1'b0;
        #1 check_quiet("reset");
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        armed = 1'b1;
        repeat (100) @(negedge clk);
        check_quiet("idle100");
        check("reset_act_int", int'(dut.act_int), 27);

        // Fractional divisor 27 + 2/16
        cfg_write(27, 2);
        repeat (3) @(negedge clk);
        obs_os.delete(); obs_bit.delete();
        n0 = cyc + 1; t = n0; acc = 0; c = 0;
        for (int k = 0; k < 32; k++) begin
            t       = t + 27 + c;
            e.cyc   = t;
            e.flags = 4 + ((k % 16 == 7) ? 2 : 0) + ((k % 16 == 15) ? 1 : 0);
            exp_q.push_back(e);
            s   = acc + 2;
            c   = s / 16;
            acc = s % 16;
        end
        last   = t;
        enable = 1'b1;
        wait_until(n0);
        check("frac_running", int'(running), 1);
        wait_until(last + 1);
        check("frac_queue_empty", exp_q.size(), 0);
        check("frac_bit_count", obs_bit.size(), 2);
        if (obs_bit.size() == 2) check("frac_bit_spacing", obs_bit[1] - obs_bit[0], 434);
        check("frac_os_count", obs_os.size(), 32);
        if (obs_os.size() == 32) begin
            n28 = 0;
            for (int i = 16; i < 32; i++) if (obs_os[i] - obs_os[i-1] == 28) n28++;
            check("frac_28_periods", n28, 2);
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("frac_stop_running", int'(running), 0);

        // Integer divisor 4, mid-bit update to 8, coincident write, resync
        cfg_write(4, 0);
        repeat (3) @(negedge clk);
        n0 = cyc + 1;
        r  = n0 + 396;
        push_ticks(n0, 4, 32, 0);
        push_ticks(n0 + 128, 8, 32, 0);
        push_ticks(n0 + 384, 4, 2, 0);
        push_ticks(r, 4, 17, 0);
        enable = 1'b1;
        wait_until(n0);
        check("div4_running", int'(running), 1);
        wait_until(n0 + 82);
        cfg_write(8, 0);
        check("upd_pending_set", int'(cfg_pending), 1);
        wait_until(n0 + 127);
        check("upd_pending_hold", int'(cfg_pending), 1);
        wait_until(n0 + 128);
        check("upd_pending_clr", int'(cfg_pending), 0);
        wait_until(n0 + 255);
        cfg_write(4, 0);
        check("coinc_pending_set", int'(cfg_pending), 1);
        check("coinc_act_int", int'(dut.act_int), 8);
        wait_until(n0 + 383);
        check("coinc_pending_hold", int'(cfg_pending), 1);
        wait_until(n0 + 384);
        check("coinc_pending_clr", int'(cfg_pending), 0);
        wait_until(r - 1);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        wait_until(r + 70);
        check("div4_queue_empty", exp_q.size(), 0);

        // Asynchronous reset mid-bit, then full-period restart
        #2 rst = 1'b0; enable = 1'b0;
        #1 check_quiet("async_rst");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_act_int", int'(dut.act_int), 27);
        n1 = cyc + 1;
        push_ticks(n1, 27, 2, 0);
        enable = 1'b1;
        // Drop enable on the cycle the third tick is due
        wait_until(n1 + 80);
        enable = 1'b0;
        @(negedge clk);
        check("drop_running", int'(running), 0);
        check("drop_os_tick", int'(os_tick), 0);
        repeat (40) @(negedge clk);
        check("drop_queue_empty", exp_q.size(), 0);
        n2 = cyc + 1;
        push_ticks(n2, 27, 2, 0);
        enable = 1'b1;
        wait_until(n2 + 55);
        check("restart_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen_frac.md
# uart_baud_gen_frac

Parametrised fractional baud-rate generator for the UART. It produces an oversampling tick, a mid-bit sample tick and a bit-boundary tick from `clk`, using a software-programmed integer plus fractional divisor. It also supports glitch-free divisor updates at bit boundaries and phase resynchronisation on RX start-bit detection. It feeds the UART TX serialiser (`bit_tick`) and the RX sampler (`os_tick`, `mid_tick`).

## Interface
Parameters:
- `OVERSAMPLE`, default 16: oversample ticks per bit; power of two, 4..32.
- `DIV_W`, default 16: width of the integer divisor.
- `FRAC_W`, default 4: width of the fractional divisor, in units of 1/2^FRAC_W.
- `DEFAULT_DIV`, default 27: reset value of the integer divisor (115200 baud at 50 MHz).

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: run generator; low forces IDLE.
- `cfg_we`  in  1: one-cycle write strobe for the shadow divisor.
- `cfg_div_int`  in  DIV_W: integer divisor; clocks per oversample period.
- `cfg_div_frac`  in  FRAC_W: fractional divisor.
- `resync`  in  1: one-cycle pulse that restarts bit phase (RX start-bit edge).
- `os_tick`  out  1: one-cycle pulse, once per oversample period.
- `mid_tick`  out  1: one-cycle pulse at the middle oversample of each bit.
- `bit_tick`  out  1: one-cycle pulse at the end of each bit.
- `cfg_pending`  out  1: shadow divisor written but not yet applied.
- `running`  out  1: high in the RUN state.

## Operation
- Two states: IDLE and RUN.
  - IDLE -> RUN when `enable`=1 and active `div_int`≠0.
  - RUN -> IDLE when `enable`=0 or active `div_int`=0; the counters clear on that edge.
- Divisor registers:
  - Shadow registers (`sh_int`, `sh_frac`) load on `cfg_we`.
  - Active registers (`act_int`, `act_frac`) copy the shadow when in IDLE, or in RUN on the cycle `bit_tick` is asserted.
  - `cfg_pending` is set by `cfg_we` and cleared on the copy. If `cfg_we` coincides with the copy, the new value is written to the shadow, `cfg_pending`=1, and the next boundary applies it.
- Fractional divider:
  - Period counter `cnt` has DIV_W+1 bits; accumulator `acc` has FRAC_W bits.
  - Oversample period P = `act_int` + carry, where carry is the overflow of `acc + act_frac` computed at the previous `os_tick`.
  - Over 2^FRAC_W periods, the average period is `act_int + act_frac/2^FRAC_W`.
- Oversample counter `os_cnt` (log2 OVERSAMPLE bits) increments on each `os_tick` and wraps OVERSAMPLE-1 -> 0.
  - `mid_tick` = `os_tick` && `os_cnt`==OVERSAMPLE/2-1.
  - `bit_tick` = `os_tick` && `os_cnt`==OVERSAMPLE-1.
- `act_int`=1 is legal: with `act_frac`=0, `os_tick` is asserted every cycle.
- `resync` in RUN: `cnt`, `acc` and `os_cnt` clear, and any tick due in that cycle is suppressed (resync wins). `resync` in IDLE is ignored.

## Timing
- Reset values:
  - All outputs are 0.
  - `act_int` = `sh_int` = DEFAULT_DIV; `act_frac` = `sh_frac` = 0.
  - Counters are 0; state is IDLE.
- All outputs are registered; the tick outputs are high for exactly one cycle.
- After the edge that moves the block to RUN, the first `os_tick` occurs exactly P cycles later, and subsequent ticks follow every P cycles.
- After a `resync` edge:
  - The first `os_tick` occurs act_int cycles later (carry is 0).
  - The first `mid_tick` occurs OVERSAMPLE/2 oversample periods later.
- A divisor copied at `bit_tick` takes effect on the period starting the next cycle; there is no partial-period glitch.
- Asynchronous reset mid-operation returns the block to reset values immediately; no tick follows until the block re-enters RUN.

## Structure
- Package `uart_baud_pkg` holds the state enum (IDLE, RUN), the OVERSAMPLE and DEFAULT_DIV defaults, and the DIV_W/FRAC_W defaults.
- Sub-module `uart_frac_divider` contains `cnt`, `acc` and the carry logic, with inputs (`act_int`, `act_frac`, `run`, `clear`) and output `os_tick`.
- The top level holds the FSM, the shadow/active registers, `os_cnt` and the tick decode.

## Test plan
- Reset, then hold `enable`=0 for 100 cycles -> all outputs 0; `act_int` reads 27.
- Set `cfg_div_int`=27, `cfg_div_frac`=2, OVERSAMPLE=16, `enable`=1 -> exactly 434 clocks between consecutive `bit_tick`s; exactly 2 periods of 28 clocks per 16 `os_tick`s.
- Set `cfg_div_int`=4, frac=0 -> `os_tick` every 4 cycles; `mid_tick` 32 cycles and `bit_tick` 64 cycles after the RUN entry edge.
- In RUN, `cfg_we` with div 8 mid-bit -> `cfg_pending`=1 until `bit_tick`; old 4-cycle period holds until that point, then 8-cycle periods begin with no short period.
- `resync` pulse on the same cycle as a due `os_tick` -> that tick is suppressed; next `os_tick` 4 cycles later; `mid_tick` 8 ticks later.
- Deassert `rst` asynchronously mid-bit, and separately drop `enable` mid-bit -> ticks stop the following cycle; `running`=0; restart yields the full-period first tick.
